// File: rtl/mem_arb_pkg.sv
// Shared definitions for the dual-requester 1R1W memory arbiter.
//   MEM_DEPTH / MEM_WIDTH / MEM_GRAN : default geometry (entries, bits, bits per mask lane)
//   MEM_AW / MEM_MASKW               : derived address and mask widths
//   state_e                          : controller state (StInit clears the macro, StRun serves)
package mem_arb_pkg;

    localparam int unsigned MEM_DEPTH = 48;
    localparam int unsigned MEM_WIDTH = 64;
    localparam int unsigned MEM_GRAN  = 8;
    localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_MASKW = MEM_WIDTH / MEM_GRAN;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with its pointer register.
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset, pointer returns to requester 0
//   valid   : request per requester
//   advance : the current grant was consumed; move the pointer past the winner
//   grant   : one-hot (or zero) grant, purely combinational from valid and pointer
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After serving requester g the other one has priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            ptr_q <= ~grant[1];
        end
    end

endmodule

// File: rtl/mem_1r1w_arb.sv
// Arbitrates two read and two write requesters onto a single 1R1W memory macro.
// Reads and writes are arbitrated independently (round-robin each). A read that
// targets the address being written in the same cycle is held off one cycle so
// it returns the new data. Out-of-range accesses are accepted but never reach
// the macro; such reads return zero.
// Optional feature: define MEM_1R1W_ARB_INIT_CLEAR_EN to clear every entry to
// zero after reset before any traffic is accepted.
// Ports:
//   clock, reset                        : clock and synchronous active-high reset
//   rd_valid/rd_ready/rd_addr           : per-requester read request channel
//   rsp_valid/rsp_data                  : one-hot read response strobe, shared data
//   wr_valid/wr_ready/wr_addr/wr_data/wr_mask : per-requester write channel
//   R0_addr/R0_en/R0_data               : macro read port (data one cycle after en)
//   W0_addr/W0_en/W0_data/W0_mask       : macro write port
//   init_done                           : block is accepting traffic
module mem_1r1w_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH,
    parameter int unsigned WIDTH = MEM_WIDTH,
    parameter int unsigned GRAN  = MEM_GRAN,
    parameter int unsigned AW    = MEM_AW,
    localparam int unsigned MASKW = WIDTH / GRAN
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 rd_valid,
    output logic [1:0]                 rd_ready,
    input  logic [1:0][AW-1:0]         rd_addr,
    output logic [1:0]                 rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    input  logic [1:0]                 wr_valid,
    output logic [1:0]                 wr_ready,
    input  logic [1:0][AW-1:0]         wr_addr,
    input  logic [1:0][WIDTH-1:0]      wr_data,
    input  logic [1:0][MASKW-1:0]      wr_mask,
    output logic [AW-1:0]              R0_addr,
    output logic                       R0_en,
    input  logic [WIDTH-1:0]           R0_data,
    output logic [AW-1:0]              W0_addr,
    output logic                       W0_en,
    output logic [WIDTH-1:0]           W0_data,
    output logic [MASKW-1:0]           W0_mask,
    output logic                       init_done
);

    logic            in_init;
    logic            run;
    logic [1:0]      rd_gnt;
    logic [1:0]      wr_gnt;
    logic            rd_sel;
    logic            wr_sel;
    logic [AW-1:0]   rd_addr_sel;
    logic [AW-1:0]   wr_addr_sel;
    logic            rd_inr;
    logic            wr_inr;
    logic            wr_xfer;
    logic            wr_mem;
    logic            collide;
    logic            rd_xfer;
    logic [1:0]      rsp_valid_q;
    logic            rsp_oor_q;

`ifdef MEM_1R1W_ARB_INIT_CLEAR_EN
    state_e          state_q, state_d;
    logic [AW-1:0]   init_addr_q, init_addr_d;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == StInit) begin
            init_addr_d = init_addr_q + AW'(1);
            if (init_addr_q == AW'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StInit;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    assign in_init = (state_q == StInit);
`else
    assign in_init = 1'b0;
`endif

    assign run       = !reset && !in_init;
    assign init_done = run;

    // Gating valid with run keeps every grant, ready and macro enable low
    // during reset and while the clear sequence owns the write port.
    rr_arb2 u_rd_arb (
        .clock   (clock),
        .reset   (reset),
        .valid   (rd_valid & {2{run}}),
        .advance (rd_xfer),
        .grant   (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clock   (clock),
        .reset   (reset),
        .valid   (wr_valid & {2{run}}),
        .advance (wr_xfer),
        .grant   (wr_gnt)
    );

    assign wr_sel      = wr_gnt[1];
    assign wr_addr_sel = wr_addr[wr_sel];
    assign wr_inr      = 32'(wr_addr_sel) < DEPTH;
    assign wr_xfer     = |wr_gnt;
    assign wr_mem      = wr_xfer && wr_inr;
    assign wr_ready    = wr_gnt;

    assign rd_sel      = rd_gnt[1];
    assign rd_addr_sel = rd_addr[rd_sel];
    assign rd_inr      = 32'(rd_addr_sel) < DEPTH;

    // Read-after-write hazard: stall the read so it sees the written data next cycle.
    assign collide  = (|rd_gnt) && wr_mem && (rd_addr_sel == wr_addr_sel);
    assign rd_xfer  = (|rd_gnt) && !collide;
    assign rd_ready = rd_xfer ? rd_gnt : 2'b00;

    assign R0_en   = rd_xfer && rd_inr;
    assign R0_addr = rd_addr_sel;

    always_comb begin
        W0_en   = wr_mem;
        W0_addr = wr_addr_sel;
        W0_data = wr_data[wr_sel];
        W0_mask = wr_mask[wr_sel];
`ifdef MEM_1R1W_ARB_INIT_CLEAR_EN
        if (!reset && in_init) begin
            W0_en   = 1'b1;
            W0_addr = init_addr_q;
            W0_data = '0;
            W0_mask = '1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q <= 2'b00;
            rsp_oor_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rd_ready;
            rsp_oor_q   <= !rd_inr;
        end
    end

    // Masking with reset drops a response that was in flight when reset arrived.
    assign rsp_valid = reset ? 2'b00 : rsp_valid_q;
    assign rsp_data  = ((|rsp_valid) && !rsp_oor_q) ? R0_data : '0;

endmodule
